// File: rtl/vs_vector_core_if.sv
// rtl/vs_vector_core_if.sv - operand/result handshake bundle for the vector core
interface vs_vector_core_if #(
    parameter int LANES  = 4,
    parameter int DATA_W = 32,
    parameter int OP_W   = 3
);
    logic                    iValid;
    logic                    oReady;
    logic [LANES*DATA_W-1:0] iA;
    logic [LANES*DATA_W-1:0] iB;
    logic [OP_W-1:0]         iOp;
    logic [LANES-1:0]        iMask;
    logic                    oValid;
    logic                    iReady;
    logic [LANES*DATA_W-1:0] oResult;
    logic                    oZero;
    logic                    oOverflow;

    modport master (
        output iValid, iA, iB, iOp, iMask, iReady,
        input  oReady, oValid, oResult, oZero, oOverflow
    );

    modport slave (
        input  iValid, iA, iB, iOp, iMask, iReady,
        output oReady, oValid, oResult, oZero, oOverflow
    );
endinterface

// File: rtl/vs_vector_core.sv
// rtl/vs_vector_core.sv - 3-stage LANES-wide integer vector ALU with masked dot product
module vs_vector_core #(
    parameter int LANES  = 4,
    parameter int DATA_W = 32,
    parameter int OP_W   = 3
) (
    input  logic            clk,
    input  logic            resetn,
    vs_vector_core_if.slave bus
);
    localparam int LOG2  = $clog2(LANES);
    localparam int SUM_W = DATA_W + LOG2;
    localparam int VEC_W = LANES * DATA_W;

    localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
    localparam logic [OP_W-1:0] OP_MUL = OP_W'(2);
    localparam logic [OP_W-1:0] OP_DP  = OP_W'(3);

    logic                     s1_v_q;
    logic [VEC_W-1:0]         s1_a_q, s1_b_q;
    logic [OP_W-1:0]          s1_op_q;
    logic [LANES-1:0]         s1_mask_q;

    logic                     s2_v_q;
    logic [VEC_W-1:0]         s2_lane_q, s2_lane_d;
    logic                     s2_ovf_q, s2_ovf_d;
    logic [OP_W-1:0]          s2_op_q;
    logic [LANES-1:0]         s2_mask_q;

    logic                     s3_v_q;
    logic [VEC_W-1:0]         s3_res_q, s3_res_d;
    logic                     s3_zero_q, s3_zero_d;
    logic                     s3_ovf_q, s3_ovf_d;

    logic signed [DATA_W-1:0]   op_a, op_b, op_r;
    logic signed [2*DATA_W-1:0] op_p;
    logic                       op_o;
    logic [SUM_W-1:0]           acc [LANES];
    logic                       dp_ovf;
    logic                       stall;

    // A full output register that downstream refuses freezes the whole pipe.
    assign stall      = s3_v_q & ~bus.iReady;
    assign bus.oReady = ~stall;

    always_comb begin
        s2_lane_d = '0;
        s2_ovf_d  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_r      = '0;
        op_p      = '0;
        op_o      = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            op_a = s1_a_q[k*DATA_W +: DATA_W];
            op_b = s1_b_q[k*DATA_W +: DATA_W];
            op_r = '0;
            op_p = '0;
            op_o = 1'b0;
            case (s1_op_q)
                OP_ADD: begin
                    op_r = op_a + op_b;
                    op_o = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (op_r[DATA_W-1] != op_a[DATA_W-1]);
                end
                OP_SUB: begin
                    op_r = op_a - op_b;
                    op_o = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (op_r[DATA_W-1] != op_a[DATA_W-1]);
                end
                OP_MUL, OP_DP: begin
                    op_p = (2*DATA_W)'(op_a) * (2*DATA_W)'(op_b);
                    op_r = op_p[DATA_W-1:0];
                    op_o = op_p[2*DATA_W-1:DATA_W-1] != {(DATA_W+1){op_p[2*DATA_W-1]}};
                end
                default: ;
            endcase
            if (s1_mask_q[k]) begin
                s2_lane_d[k*DATA_W +: DATA_W] = op_r;
                s2_ovf_d                      = s2_ovf_d | op_o;
            end
        end
    end

    // In-place pairwise reduction: each level halves the live width, giving log2(LANES) adder levels.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            acc[k] = {{LOG2{s2_lane_q[k*DATA_W+DATA_W-1]}}, s2_lane_q[k*DATA_W +: DATA_W]};
        end
        for (int l = 0; l < LOG2; l++) begin
            for (int i = 0; i < (LANES >> (l + 1)); i++) begin
                acc[i] = acc[2*i] + acc[2*i+1];
            end
        end
        dp_ovf   = acc[0][SUM_W-1:DATA_W-1] != {(LOG2+1){acc[0][SUM_W-1]}};
        s3_res_d = s2_lane_q;
        s3_ovf_d = s2_ovf_q;
        if (s2_op_q == OP_DP) begin
            s3_res_d = '0;
            for (int k = 0; k < LANES; k++) begin
                if (s2_mask_q[k]) begin
                    s3_res_d[k*DATA_W +: DATA_W] = acc[0][DATA_W-1:0];
                end
            end
            s3_ovf_d = s2_ovf_q | dp_ovf;
        end
        s3_zero_d = (s3_res_d == '0);
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            s1_v_q    <= 1'b0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s1_op_q   <= '0;
            s1_mask_q <= '0;
            s2_v_q    <= 1'b0;
            s2_lane_q <= '0;
            s2_ovf_q  <= 1'b0;
            s2_op_q   <= '0;
            s2_mask_q <= '0;
            s3_v_q    <= 1'b0;
            s3_res_q  <= '0;
            s3_zero_q <= 1'b0;
            s3_ovf_q  <= 1'b0;
        end else if (!stall) begin
            s1_v_q <= bus.iValid;
            if (bus.iValid) begin
                s1_a_q    <= bus.iA;
                s1_b_q    <= bus.iB;
                s1_op_q   <= bus.iOp;
                s1_mask_q <= bus.iMask;
            end
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                s2_lane_q <= s2_lane_d;
                s2_ovf_q  <= s2_ovf_d;
                s2_op_q   <= s1_op_q;
                s2_mask_q <= s1_mask_q;
            end
            s3_v_q <= s2_v_q;
            if (s2_v_q) begin
                s3_res_q  <= s3_res_d;
                s3_zero_q <= s3_zero_d;
                s3_ovf_q  <= s3_ovf_d;
            end
        end
    end

    assign bus.oValid    = s3_v_q;
    assign bus.oResult   = s3_res_q;
    assign bus.oZero     = s3_zero_q;
    assign bus.oOverflow = s3_ovf_q;
endmodule

// File: tb/tb_vs_vector_core.sv
// tb/tb_vs_vector_core.sv - scoreboard bench for vs_vector_core with directed vectors
module tb_vs_vector_core;
    localparam int LANES  = 4;
    localparam int DATA_W = 32;
    localparam int OP_W   = 3;

    localparam logic [2:0] ADD = 3'd0;
    localparam logic [2:0] SUB = 3'd1;
    localparam logic [2:0] MUL = 3'd2;
    localparam logic [2:0] DP  = 3'd3;
    localparam logic [2:0] NOP = 3'd4;

    typedef struct {
        logic [127:0] res;
        logic         zero;
        logic         ovf;
        int           t;
        bit           lat;
    } exp_t;

    logic       clk        = 1'b0;
    logic       resetn     = 1'b1;
    logic       iready_drv = 1'b1;
    bit         bp_mode    = 1'b0;
    int         bp_idx     = 0;
    logic [3:0] bp_pat     = 4'b1001;
    int         cyc        = 0;
    int         n_total    = 0;
    int         n_pass     = 0;
    bit         prev_stall = 1'b0;
    logic [2:0] prev_flags;
    logic [127:0] prev_res;
    exp_t       sb[$];
    exp_t       e;

    vs_vector_core_if #(.LANES(LANES), .DATA_W(DATA_W), .OP_W(OP_W)) bus ();
    assign bus.iReady = iready_drv;

    vs_vector_core #(.LANES(LANES), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (bp_mode) begin
            iready_drv = bp_pat[bp_idx];
            bp_idx     = (bp_idx + 1) % 4;
        end else begin
            iready_drv = 1'b1;
        end
    end

    function automatic logic [127:0] v4(input int a0, input int a1, input int a2, input int a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [127:0] rep(input int x);
        return {x, x, x, x};
    endfunction

    task automatic chk_v(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic send(input logic [127:0] a, input logic [127:0] b, input logic [2:0] op,
                        input logic [3:0] m, input logic [127:0] er, input logic ez,
                        input logic eo, input bit push);
        bit ok;
        ok          = 1'b0;
        bus.iValid  = 1'b1;
        bus.iA      = a;
        bus.iB      = b;
        bus.iOp     = op;
        bus.iMask   = m;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (bus.oReady === 1'b1) begin
                ok = 1'b1;
                if (push) sb.push_back('{res: er, zero: ez, ovf: eo, t: cyc, lat: !bp_mode});
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_total++;
            $display("FAIL accept_timeout: oReady stayed low for 64 cycles, wanted 1");
        end
    endtask

    task automatic drain();
        bus.iValid = 1'b0;
        for (int i = 0; i < 200 && sb.size() > 0; i++) @(posedge clk);
        #1;
        chk_i("drain_empty", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!resetn) begin
            chk_i("oready_rule", int'(bus.oReady), int'(!(bus.oValid && !bus.iReady)));
            if (prev_stall) begin
                chk_i("stall_hold_flags", int'({bus.oValid, bus.oZero, bus.oOverflow}), int'(prev_flags));
                chk_v("stall_hold_result", bus.oResult, prev_res);
            end
            if (bus.oValid && bus.iReady) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_output: got result %h with empty scoreboard", bus.oResult);
                end else begin
                    e = sb.pop_front();
                    chk_v("result", bus.oResult, e.res);
                    chk_i("zero", int'(bus.oZero), int'(e.zero));
                    chk_i("overflow", int'(bus.oOverflow), int'(e.ovf));
                    if (e.lat) chk_i("latency", cyc - e.t, 3);
                end
            end
            prev_stall = bus.oValid && !bus.iReady;
            prev_flags = {bus.oValid, bus.oZero, bus.oOverflow};
            prev_res   = bus.oResult;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.iValid = 1'b0;
        bus.iA     = '0;
        bus.iB     = '0;
        bus.iOp    = '0;
        bus.iMask  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_i("rst_ovalid", int'(bus.oValid), 0);
        chk_v("rst_result", bus.oResult, '0);
        chk_i("rst_zero", int'(bus.oZero), 0);
        chk_i("rst_ovf", int'(bus.oOverflow), 0);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;

        // first result reaches the output, two more are in flight when reset hits
        send(v4(1, 2, 3, 4), v4(1, 2, 3, 4), DP, 4'hF, rep(30), 1'b0, 1'b0, 1'b1);
        send(v4(5, 5, 5, 5), v4(5, 5, 5, 5), ADD, 4'hF, '0, 1'b0, 1'b0, 1'b0);
        send(v4(7, 7, 7, 7), v4(1, 1, 1, 1), SUB, 4'hF, '0, 1'b0, 1'b0, 1'b0);
        bus.iValid = 1'b0;
        #6;
        resetn = 1'b1;
        #1;
        chk_i("inflight_rst_ovalid", int'(bus.oValid), 0);
        chk_v("inflight_rst_result", bus.oResult, '0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        send(v4(1, 2, 3, 4), v4(1, 2, 3, 4), DP, 4'hF, rep(30), 1'b0, 1'b0, 1'b1);

        // directed boundaries
        send(v4(2, 3, 4, 100), v4(5, 6, 7, 100), DP, 4'b0111, v4(56, 56, 56, 0), 1'b0, 1'b0, 1'b1);
        send(v4(32'h7FFFFFFF, 0, 0, 0), v4(1, 0, 0, 0), ADD, 4'b0001, v4(32'h80000000, 0, 0, 0), 1'b0, 1'b1, 1'b1);
        send(v4(5, 32'h7FFFFFFF, 0, 0), v4(6, 1, 0, 0), ADD, 4'b0001, v4(11, 0, 0, 0), 1'b0, 1'b0, 1'b1);
        send(v4(32'h10000, 7, 7, 7), v4(32'h10000, 7, 7, 7), MUL, 4'b0001, '0, 1'b1, 1'b1, 1'b1);
        send(rep(32'h40000000), rep(1), DP, 4'hF, '0, 1'b1, 1'b1, 1'b1);
        send(v4(32'h10000, 0, 0, 0), v4(32'h10000, 0, 0, 0), DP, 4'hF, '0, 1'b1, 1'b1, 1'b1);
        send(v4(9, 8, 7, 6), v4(1, 2, 3, 4), DP, 4'b0000, '0, 1'b1, 1'b0, 1'b1);
        send(rep(-3), v4(1, 2, 3, 4), DP, 4'hF, rep(-30), 1'b0, 1'b0, 1'b1);
        send(v4(32'h80000000, 0, 0, 0), v4(-1, 0, 0, 0), SUB, 4'b0001, v4(32'h80000001, 0, 0, 0), 1'b0, 1'b0, 1'b1);
        drain();

        // full throughput, mixed ops back to back
        send(v4(1, 2, 3, 4), v4(10, 20, 30, 40), ADD, 4'hF, v4(11, 22, 33, 44), 1'b0, 1'b0, 1'b1);
        send(v4(10, 20, 30, 40), v4(1, 2, 3, 4), SUB, 4'hF, v4(9, 18, 27, 36), 1'b0, 1'b0, 1'b1);
        send(v4(2, 3, 4, 5), v4(6, 7, 8, 9), MUL, 4'hF, v4(12, 21, 32, 45), 1'b0, 1'b0, 1'b1);
        send(v4(1, 1, 1, 1), v4(5, 6, 7, 8), DP, 4'hF, rep(26), 1'b0, 1'b0, 1'b1);
        send(v4(1, 2, 3, 4), v4(9, 9, 9, 9), NOP, 4'hF, '0, 1'b1, 1'b0, 1'b1);
        send(v4(0, 0, 0, 0), v4(1, 2, 3, 4), SUB, 4'hF, v4(-1, -2, -3, -4), 1'b0, 1'b0, 1'b1);
        send(v4(-2, 3, -4, 5), v4(3, -3, -4, 0), MUL, 4'hF, v4(-6, -9, 16, 0), 1'b0, 1'b0, 1'b1);
        send(v4(-1, -1, 5, 0), v4(1, 1, -5, 0), ADD, 4'hF, '0, 1'b1, 1'b0, 1'b1);
        send(v4(-1, 2, -3, 4), rep(1), DP, 4'hF, rep(2), 1'b0, 1'b0, 1'b1);
        send(rep(32'h7FFFFFFF), rep(32'h7FFFFFFF), 3'd5, 4'hF, '0, 1'b1, 1'b0, 1'b1);
        send(v4(1, 2, 3, 4), rep(1), ADD, 4'b1010, v4(0, 3, 0, 5), 1'b0, 1'b0, 1'b1);
        send(v4(32'h7FFFFFFF, 3, 3, 3), v4(2, 3, 3, 3), MUL, 4'b0001, v4(-2, 0, 0, 0), 1'b0, 1'b1, 1'b1);
        send(v4(32'h80000000, 0, 0, 0), v4(1, 0, 0, 0), SUB, 4'b0001, v4(32'h7FFFFFFF, 0, 0, 0), 1'b0, 1'b1, 1'b1);
        send(v4(9, 9, 3, 4), v4(9, 9, 5, 6), DP, 4'b1100, v4(0, 0, 39, 39), 1'b0, 1'b0, 1'b1);
        send(rep(6), rep(6), 3'd7, 4'b0000, '0, 1'b1, 1'b0, 1'b1);
        send(v4(100, 200, 300, 400), rep(1), ADD, 4'hF, v4(101, 201, 301, 401), 1'b0, 1'b0, 1'b1);
        drain();

        // back-pressure with iReady pattern 1,0,0,1
        bp_idx  = 0;
        bp_mode = 1'b1;
        for (int k = 0; k < 8; k++) begin
            send(rep(k), rep(k), ADD, 4'hF, rep(2 * k), (k == 0), 1'b0, 1'b1);
        end
        drain();
        bp_mode = 1'b0;
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/vs_vector_core.md
Name: vs_vector_core

Overview:
- Parametrised successor to the vertex shader ALU core: LANES-wide integer vector unit for per-lane ADD/SUB/MUL and masked dot product (DP3/DP4/DPn via lane mask).
- Fixed 3-stage pipeline with full valid/ready flow control on input and output.
- Overflow is reported from every stage, not only the reduction stage.
- Sits between the vertex-shader operand fetch and the register writeback.

Parameters:
- LANES, 4, number of vector lanes; power of two, ≥2.
- DATA_W, 32, lane width; two's-complement signed.
- OP_W, 3, opcode width.

Ports:
- clk  in  1  clock; all state on rising edge.
- resetn  in  1  asynchronous reset, active-high (1 = reset asserted); clears all state immediately.
- iValid  in  1  input operand valid.
- oReady  out  1  core accepts input this cycle.
- iA  in  LANES*DATA_W  operand A; lane k at [k*DATA_W +: DATA_W].
- iB  in  LANES*DATA_W  operand B; same packing.
- iOp  in  OP_W  0 ADD, 1 SUB, 2 MUL, 3 DP; 4–7 NOP.
- iMask  in  LANES  lane enable. Disabled lanes produce 0 and do not contribute to DP.
- oValid  out  1  result valid.
- iReady  in  1  downstream accepts result.
- oResult  out  LANES*DATA_W  vector result; DP broadcasts the scalar sum to all enabled lanes.
- oZero  out  1  all LANES of oResult equal 0.
- oOverflow  out  1  signed overflow anywhere in this transaction.

Behaviour:
- Reset values: oValid=0, oResult=0, oZero=0, oOverflow=0. All stage valid bits are 0; reset mid-operation discards in-flight transactions.
- Handshake:
  - Input transfer occurs when iValid & oReady.
  - Output transfer occurs when oValid & iReady.
  - oValid, oResult, oZero and oOverflow hold stable while oValid & !iReady.
- Pipeline: S1 operand register, S2 lane op, S3 reduction/output. Each stage holds a valid bit.
  - stall = oValid & !iReady. When stalled, every stage holds; otherwise every stage advances.
  - oReady = !stall (combinational from iReady and S3 valid).
- Latency: 3 cycles from the accepting edge to oValid. Throughput 1 per cycle with no bubbles while iReady=1.
- Empty stages advance freely: a bubble never blocks a later transaction when not stalled.
- S2 lane op (enabled lanes only; disabled lanes give 0 with no overflow):
  - ADD: A+B, wrap to DATA_W. Overflow if operand signs are equal and the result sign differs.
  - SUB: A−B, wrap to DATA_W. Overflow if operand signs differ and the result sign differs from A.
  - MUL: full 2*DATA_W product, low DATA_W kept. Overflow if the product is outside signed DATA_W range.
  - NOP: all lanes 0; overflow 0; oValid still asserted.
- S3:
  - Non-DP ops: pass the lane vector through.
  - DP: balanced adder tree of log2(LANES) levels over enabled lane products, summed at DATA_W+log2(LANES) bits. Result is truncated to DATA_W. Overflow if the wide sum is out of signed DATA_W range OR any lane product overflowed in S2.
  - DP with iMask=0: result 0, oZero=1, oOverflow=0.
- oZero is computed on the final DATA_W-truncated vector.
- oOverflow is the OR of S2 and S3 overflow for that transaction; it is not sticky across transactions.
- Opcode and mask are captured in S1 with the operands and travel with the transaction. Back-to-back transactions with different ops must not interfere.
- Simultaneous accept and output transfer in the same cycle is legal; no cycle is lost.

Test Plan:
- Reset: assert resetn with 2 transactions in flight, then release → oValid=0, oResult=0; the next accepted DP4 of A=B={1,2,3,4} gives 30 on all lanes 3 cycles later.
- DP3 via mask: A={2,3,4,100}, B={5,6,7,100}, iMask=0111, iOp=3 → lanes 0–2 = 56, lane 3 = 0, oOverflow=0, oZero=0.
- Overflow paths (DATA_W=32):
  - ADD lane0 0x7FFFFFFF+1 → 0x80000000, oOverflow=1.
  - MUL 0x10000×0x10000 → 0, oOverflow=1, oZero=1 (only lane0 enabled).
  - DP4 of four 0x40000000×1 → oOverflow=1.
- Back-pressure: stream 8 ADD transactions (A=k, B=k, k=0..7) with iReady toggling 1,0,0,1,… → outputs 0,2,…,14 in order, none dropped or duplicated, oResult stable during stall, oReady=0 exactly when oValid&!iReady.
- Full throughput: iReady=1, 16 consecutive mixed ADD/SUB/MUL/DP/NOP inputs → 16 results on consecutive cycles starting cycle 3, each matching its own op; NOP yields 0 with oZero=1.
- Empty DP mask: iOp=3, iMask=0000, arbitrary operands → oResult=0, oZero=1, oOverflow=0.
